// File: rtl/uart_tx_frame_if.sv
// Stream and line signals of the UART transmitter; the source uses master and the transmitter uses slave.
interface uart_tx_frame_if #(
   parameter int DATA_BITS = 8
);
   logic                 uart_wr_i;
   logic [DATA_BITS-1:0] uart_dat_i;
   logic                 uart_rdy_o;
   logic                 uart_busy_o;
   logic                 uart_done_o;
   logic                 uart_tx;

   modport master (
      output uart_wr_i, uart_dat_i,
      input  uart_rdy_o, uart_busy_o, uart_done_o, uart_tx
   );

   modport slave (
      input  uart_wr_i, uart_dat_i,
      output uart_rdy_o, uart_busy_o, uart_done_o, uart_tx
   );
endinterface

// File: rtl/uart_tx_frame.sv
// Parametrised UART transmitter with fractional baud accumulator, parity and frame-done strobe.
// Define UART_TX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry input FIFO.
//
// state  | meaning
// IDLE   | line high, waiting for a queued word
// START  | start bit (low)
// DATA   | payload bits, LSB first
// PARITY | parity bit of the captured word
// STOP   | STOP_BITS high bits, then done pulse
module uart_tx_frame #(
   parameter int CLK_HZ     = 100000000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY     = 0,
   parameter int FIFO_DEPTH = 4
) (
   input  logic           sys_clk_i,
   input  logic           sys_rst_i,
   uart_tx_frame_if.slave bus
);

   localparam int ACC_W = $clog2(CLK_HZ) + 1;
   localparam logic [ACC_W-1:0] ACC_BAUD = ACC_W'(BAUD);
   localparam logic [ACC_W-1:0] ACC_WRAP = ACC_W'(CLK_HZ - BAUD);

   if (DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 || STOP_BITS > 2 ||
       PARITY < 0 || PARITY > 2 || BAUD * 2 > CLK_HZ ||
       FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
      $error("uart_tx_frame: illegal parameter set");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t               state_q, state_d;
   logic [ACC_W-1:0]     acc_q, acc_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 rdy_q, rdy_d;
   logic                 tick, load, push;
   logic                 avail, avail_d, full_d;
   logic [DATA_BITS-1:0] head;

   assign tick = (acc_q >= ACC_WRAP);
   assign push = bus.uart_wr_i & rdy_q;

`ifdef UART_TX_FIFO_EN
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]       count_q, count_d;

   assign head    = fifo_mem[rd_ptr_q];
   assign avail   = (count_q != '0);
   assign avail_d = (count_d != '0);
   assign full_d  = (count_d == (PTR_W+1)'(FIFO_DEPTH));

   always_comb begin
      count_d = count_q;
      if (push && !load)
         count_d = count_q + (PTR_W+1)'(1);
      else if (!push && load)
         count_d = count_q - (PTR_W+1)'(1);
   end

   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push)
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (load)
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_d;
      end
   end

   always_ff @(posedge sys_clk_i) begin
      if (push)
         fifo_mem[wr_ptr_q] <= bus.uart_dat_i;
   end
`else
   logic                 hold_vld_q, hold_vld_d;
   logic [DATA_BITS-1:0] hold_dat_q;

   assign head       = hold_dat_q;
   assign avail      = hold_vld_q;
   assign hold_vld_d = push | (hold_vld_q & ~load);
   assign avail_d    = hold_vld_d;
   assign full_d     = hold_vld_d;

   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         hold_vld_q <= 1'b0;
         hold_dat_q <= '0;
      end else begin
         hold_vld_q <= hold_vld_d;
         if (push)
            hold_dat_q <= bus.uart_dat_i;
      end
   end
`endif

   always_ff @(posedge sys_clk_i) begin
      if (sys_rst_i) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rdy_q   <= rdy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (avail) begin
               load    = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick)
               state_d = S_DATA;
         end
         S_DATA: begin
            if (tick && cnt_q == 4'd1)
               state_d = (PARITY != 0) ? S_PARITY : S_STOP;
         end
         S_PARITY: begin
            if (tick)
               state_d = S_STOP;
         end
         S_STOP: begin
            if (tick && cnt_q == 4'd1) begin
               if (avail) begin
                  load    = 1'b1;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      acc_d   = acc_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      par_d   = par_q;
      // Parity is latched from the word at load time, so shifting never disturbs it.
      if (load) begin
         acc_d   = '0;
         shift_d = head;
         par_d   = (PARITY == 1) ? ~(^head) : (^head);
      end else if (state_q != S_IDLE) begin
         acc_d = tick ? (acc_q - ACC_WRAP) : (acc_q + ACC_BAUD);
      end
      if (state_q == S_DATA && tick)
         shift_d = shift_q >> 1;
      // Down-counter of bits left in the current DATA or STOP phase.
      if (state_d != state_q) begin
         if (state_d == S_DATA)
            cnt_d = 4'(DATA_BITS);
         else if (state_d == S_STOP)
            cnt_d = 4'(STOP_BITS);
      end else if (tick && (state_q == S_DATA || state_q == S_STOP)) begin
         cnt_d = cnt_q - 4'd1;
      end
   end

   always_comb begin
      tx_d = 1'b1;
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
         S_PARITY: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE) || avail_d;
      done_d = (state_q == S_STOP) && tick && (cnt_q == 4'd1);
      rdy_d  = ~full_d;
   end

   assign bus.uart_tx     = tx_q;
   assign bus.uart_busy_o = busy_q;
   assign bus.uart_done_o = done_q;
   assign bus.uart_rdy_o  = rdy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four parameter sets, line levels checked against a per-bit frame model.
`timescale 1ns/1ps
module tb_uart_tx_frame;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_d = 1'b0;
   logic [8:0] dat_d = '0;
   int         sel = 0;
   int         n_chk = 0;
   int         n_fail = 0;
   logic       tx_m, done_m, rdy_m, busy_m;

   always #5 clk = ~clk;

`ifdef UART_TX_FIFO_EN
   localparam int   EXP_FIRST_DROP = 5;
   localparam logic EXP_B2B_RDY    = 1'b1;
`else
   localparam int   EXP_FIRST_DROP = 1;
   localparam logic EXP_B2B_RDY    = 1'b0;
`endif

   uart_tx_frame_if #(.DATA_BITS(8)) bus0 ();
   uart_tx_frame_if #(.DATA_BITS(7)) bus1 ();
   uart_tx_frame_if #(.DATA_BITS(7)) bus2 ();
   uart_tx_frame_if #(.DATA_BITS(8)) bus3 ();

   assign bus0.uart_wr_i  = wr_d && (sel == 0);
   assign bus1.uart_wr_i  = wr_d && (sel == 1);
   assign bus2.uart_wr_i  = wr_d && (sel == 2);
   assign bus3.uart_wr_i  = wr_d && (sel == 3);
   assign bus0.uart_dat_i = dat_d[7:0];
   assign bus1.uart_dat_i = dat_d[6:0];
   assign bus2.uart_dat_i = dat_d[6:0];
   assign bus3.uart_dat_i = dat_d[7:0];

   uart_tx_frame #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .STOP_BITS(1), .PARITY(0), .FIFO_DEPTH(4))
      dut0 (.sys_clk_i(clk), .sys_rst_i(rst), .bus(bus0.slave));
   uart_tx_frame #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(7), .STOP_BITS(2), .PARITY(2), .FIFO_DEPTH(4))
      dut1 (.sys_clk_i(clk), .sys_rst_i(rst), .bus(bus1.slave));
   uart_tx_frame #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(7), .STOP_BITS(2), .PARITY(1), .FIFO_DEPTH(4))
      dut2 (.sys_clk_i(clk), .sys_rst_i(rst), .bus(bus2.slave));
   uart_tx_frame #(.CLK_HZ(100000000), .BAUD(115200), .DATA_BITS(8), .STOP_BITS(1), .PARITY(0), .FIFO_DEPTH(4))
      dut3 (.sys_clk_i(clk), .sys_rst_i(rst), .bus(bus3.slave));

   always_comb begin
      case (sel)
         1:       begin tx_m = bus1.uart_tx; done_m = bus1.uart_done_o; rdy_m = bus1.uart_rdy_o; busy_m = bus1.uart_busy_o; end
         2:       begin tx_m = bus2.uart_tx; done_m = bus2.uart_done_o; rdy_m = bus2.uart_rdy_o; busy_m = bus2.uart_busy_o; end
         3:       begin tx_m = bus3.uart_tx; done_m = bus3.uart_done_o; rdy_m = bus3.uart_rdy_o; busy_m = bus3.uart_busy_o; end
         default: begin tx_m = bus0.uart_tx; done_m = bus0.uart_done_o; rdy_m = bus0.uart_rdy_o; busy_m = bus0.uart_busy_o; end
      endcase
   end

   // Frame position k: 0 start, 1..db data LSB first, then optional parity, then stop bits.
   function automatic logic exp_bit(input logic [8:0] d, input int db, input int par, input int k);
      logic p;
      p = 1'b0;
      if (k == 0) return 1'b0;
      if (k <= db) return d[k-1];
      if (par != 0 && k == db + 1) begin
         for (int i = 0; i < db; i++) p = p ^ d[i];
         return (par == 1) ? ~p : p;
      end
      return 1'b1;
   endfunction

   task automatic send(input logic [8:0] d);
      int n;
      n = 0;
      dat_d = d;
      wr_d  = 1'b1;
      while (rdy_m !== 1'b1 && n < 4000) begin
         @(negedge clk);
         n++;
      end
      n_chk++;
      if (rdy_m !== 1'b1) begin
         n_fail++;
         $display("FAIL send_accept: rdy=%b after %0d cycles, required 1", rdy_m, n);
      end
      @(negedge clk);
   endtask

   task automatic check_frame(input logic [8:0] d, input int db, input int sb, input int par,
                              input int cpb, input int tol, input string tag);
      int   cyc, nb, expd;
      logic early;
      nb    = 1 + db + ((par != 0) ? 1 : 0) + sb;
      expd  = nb * cpb;
      early = 1'b0;
      cyc   = 0;
      while (tx_m !== 1'b0 && cyc < 4000) begin
         @(negedge clk);
         cyc++;
      end
      n_chk++;
      if (tx_m !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_start: tx=%b after %0d cycles, required 0", tag, tx_m, cyc);
         return;
      end
      cyc = 0;
      for (int k = 0; k < nb; k++) begin
         while (cyc < k * cpb + cpb / 2) begin
            @(negedge clk);
            cyc++;
            if (done_m === 1'b1) early = 1'b1;
         end
         n_chk++;
         if (tx_m !== exp_bit(d, db, par, k)) begin
            n_fail++;
            $display("FAIL %s_bit%0d: tx=%b, required %b (data %h)", tag, k, tx_m, exp_bit(d, db, par, k), d);
         end
      end
      while (done_m !== 1'b1 && cyc < expd + tol) begin
         @(negedge clk);
         cyc++;
      end
      n_chk++;
      if (early || done_m !== 1'b1 || cyc < expd - tol) begin
         n_fail++;
         $display("FAIL %s_done: done=%b at cycle %0d (early %b), required pulse at %0d +/- %0d",
                  tag, done_m, cyc, early, expd, tol);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      for (int s = 0; s < 4; s++) begin
         sel = s;
         #1;
         n_chk++;
         if ({tx_m, busy_m, done_m, rdy_m} !== 4'b1000) begin
            n_fail++;
            $display("FAIL reset_outputs dut%0d: tx/busy/done/rdy=%b, required 1000", s, {tx_m, busy_m, done_m, rdy_m});
         end
      end
      rst = 1'b0;
      @(negedge clk);
      for (int s = 0; s < 4; s++) begin
         sel = s;
         #1;
         n_chk++;
         if ({rdy_m, busy_m, tx_m} !== 3'b101) begin
            n_fail++;
            $display("FAIL reset_release dut%0d: rdy/busy/tx=%b, required 101", s, {rdy_m, busy_m, tx_m});
         end
      end
      sel = 0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      sel = 0;
      @(negedge clk);
      send(9'h0A5);
      wr_d = 1'b0;
      n_chk++;
      if (tx_m !== 1'b1 || busy_m !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_accept: tx=%b busy=%b, required tx=1 busy=1", tx_m, busy_m);
      end
      @(negedge clk);
      n_chk++;
      if (tx_m !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_start_latency: tx=%b one cycle after accept, required 0", tx_m);
      end
      check_frame(9'h0A5, 8, 1, 0, 16, 0, "basic");
      n_chk++;
      if (busy_m !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_busy_clear: busy=%b at done, required 0", busy_m);
      end
      @(negedge clk);
      n_chk++;
      if (done_m !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_done_single: done=%b one cycle after pulse, required 0", done_m);
      end
   endtask

   task automatic test_parity();
      logic [8:0] d;
      for (int r = 0; r < 3; r++) begin
         d = (r == 0) ? 9'h041 : 9'($urandom_range(0, 127));
         sel = 1;
         @(negedge clk);
         send(d);
         wr_d = 1'b0;
         check_frame(d, 7, 2, 2, 16, 0, "even7e2");
         sel = 2;
         @(negedge clk);
         send(d);
         wr_d = 1'b0;
         check_frame(d, 7, 2, 1, 16, 0, "odd7o2");
      end
      sel = 0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      sel = 0;
      @(negedge clk);
      fork
         begin
            send(9'h000);
            n_chk++;
            if (rdy_m !== EXP_B2B_RDY) begin
               n_fail++;
               $display("FAIL b2b_rdy_first: rdy=%b, required %b", rdy_m, EXP_B2B_RDY);
            end
            send(9'h0FF);
            n_chk++;
            if (rdy_m !== EXP_B2B_RDY) begin
               n_fail++;
               $display("FAIL b2b_rdy_second: rdy=%b, required %b", rdy_m, EXP_B2B_RDY);
            end
            wr_d = 1'b0;
         end
         begin
            check_frame(9'h000, 8, 1, 0, 16, 0, "b2b_first");
            n_chk++;
            if (tx_m !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_gap: tx=%b on done cycle, required 0", tx_m);
            end
            check_frame(9'h0FF, 8, 1, 0, 16, 0, "b2b_second");
         end
      join
   endtask

   task automatic test_backpressure();
      logic [8:0] w [6];
      int         first_drop;
      first_drop = 0;
      for (int i = 0; i < 6; i++) w[i] = 9'($urandom_range(0, 255));
      sel = 0;
      @(negedge clk);
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               send(w[i]);
               if (rdy_m === 1'b0 && first_drop == 0) first_drop = i + 1;
            end
            wr_d = 1'b0;
            n_chk++;
            if (first_drop != EXP_FIRST_DROP) begin
               n_fail++;
               $display("FAIL bp_first_drop: rdy fell after accept %0d, required %0d", first_drop, EXP_FIRST_DROP);
            end
         end
         begin
            for (int i = 0; i < 6; i++) check_frame(w[i], 8, 1, 0, 16, 0, "bp_word");
         end
      join
   endtask

   task automatic test_reset_mid_frame();
      logic [8:0] d;
      int         n, n_done, n_low;
      d = 9'($urandom_range(0, 255));
      sel = 0;
      @(negedge clk);
      send(d);
      wr_d = 1'b0;
      n = 0;
      while (tx_m !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      repeat (4 * 16 + 8) @(negedge clk);
      n_chk++;
      if (tx_m !== d[3]) begin
         n_fail++;
         $display("FAIL rst_mid_bit3: tx=%b, required %b", tx_m, d[3]);
      end
      rst = 1'b1;
      @(negedge clk);
      n_chk++;
      if ({tx_m, busy_m, done_m, rdy_m} !== 4'b1000) begin
         n_fail++;
         $display("FAIL rst_mid_abort: tx/busy/done/rdy=%b, required 1000", {tx_m, busy_m, done_m, rdy_m});
      end
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if (rdy_m !== 1'b1 || busy_m !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_release: rdy=%b busy=%b, required rdy=1 busy=0", rdy_m, busy_m);
      end
      n_done = 0;
      n_low  = 0;
      repeat (200) begin
         @(negedge clk);
         if (done_m === 1'b1) n_done++;
         if (tx_m !== 1'b1) n_low++;
      end
      n_chk++;
      if (n_done != 0) begin
         n_fail++;
         $display("FAIL rst_mid_no_done: %0d done pulses after abort, required 0", n_done);
      end
      n_chk++;
      if (n_low != 0) begin
         n_fail++;
         $display("FAIL rst_mid_idle: %0d non-high line cycles after abort, required 0", n_low);
      end
      send(9'h03C);
      wr_d = 1'b0;
      check_frame(9'h03C, 8, 1, 0, 16, 0, "rst_fresh");
   endtask

   task automatic test_real_rate();
      sel = 3;
      @(negedge clk);
      send(9'h055);
      wr_d = 1'b0;
      check_frame(9'h055, 8, 1, 0, 868, 1, "real_rate");
      sel = 0;
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_parity();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_frame();
      test_real_rate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter. It serialises bytes from a valid/ready stream onto a single TX line. Data width, stop-bit count, parity mode, baud rate and clock frequency are all compile-time parameters. It replaces the fixed 8N1/115200 transmitter in the SoC peripheral block and adds backpressure, parity, a frame-done strobe and an optional input FIFO.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
BAUD, 115200, line rate in bit/s; must satisfy BAUD*2 <= CLK_HZ
DATA_BITS, 8, payload bits per frame, legal range 5..9
STOP_BITS, 1, stop bits per frame, 1 or 2
PARITY, 0, 0 = none, 1 = odd, 2 = even
FIFO_DEPTH, 4, entries in the input FIFO (power of two, >= 2); used only with UART_TX_FIFO_EN

Ports:
sys_clk_i  in  1  system clock, all logic on rising edge
sys_rst_i  in  1  reset, synchronous, active-high
uart_wr_i  in  1  valid: a data word is offered
uart_dat_i  in  DATA_BITS  data word, LSB transmitted first
uart_rdy_o  out  1  ready: a word is accepted on a cycle where uart_wr_i && uart_rdy_o
uart_busy_o  out  1  high while a frame is on the line or a word is queued
uart_done_o  out  1  one-cycle pulse on the cycle the last stop bit completes
uart_tx  out  1  serial line, idle high

Behaviour:
- Reset (sys_rst_i high at a clock edge): uart_tx=1, uart_rdy_o=0 during reset, uart_busy_o=0, uart_done_o=0, state=IDLE, accumulator=0, FIFO empty. Reset mid-frame aborts the frame immediately; uart_tx returns high on the next edge.
- uart_rdy_o goes to 1 on the first cycle after reset deasserts.
- Baud tick, fractional accumulator, width ceil(log2(CLK_HZ))+1:
  - If acc >= CLK_HZ-BAUD: acc <= acc+BAUD-CLK_HZ and tick=1.
  - Otherwise: acc <= acc+BAUD and tick=0.
  - acc is cleared to 0 on the cycle a frame starts, so the start bit has full width.
- Bit length: each bit lasts from frame start, or from the previous tick, up to and including the next tick. With CLK_HZ=16 and BAUD=1 that is exactly 16 cycles per bit.
- States:
  - IDLE: uart_tx=1. If a word is available (holding register or FIFO non-empty), load the shifter, clear acc, go to START. uart_tx=0 on the next edge, so latency from the accept edge to the start bit is 1 cycle.
  - START: on tick, go to DATA with bit index 0.
  - DATA: uart_tx=shifter[0]. On tick, shift right and increment the index. After DATA_BITS ticks, go to PARITY if PARITY != 0, else to STOP.
  - PARITY: uart_tx = XOR of the data bits for even parity, its inverse for odd parity. On tick, go to STOP.
  - STOP: uart_tx=1 for STOP_BITS ticks. Then pulse uart_done_o.
    - If another word is available, go straight to START on that same edge (back-to-back frames, no idle gap).
    - Otherwise go to IDLE.
- Parity is computed from the word as it was captured, not from the live shifter.
- Handshake, without FIFO: single holding register. uart_rdy_o=1 when the holding register is empty. A frame start moves the word from the holding register into the shifter, so one word can be accepted while another is being sent.
- Simultaneous accept and frame start on the same cycle: the accepted word enters the holding register, or the FIFO tail; the word being loaded comes from the head. No loss and no duplication.
- uart_wr_i while uart_rdy_o=0: ignored, no state change. The source must hold the word.
- uart_busy_o = (state != IDLE) || word pending. It is registered and follows state with no lag on the same edge.

Optional Feature:
UART_TX_FIFO_EN
- Defined: the holding register is replaced by a FIFO of FIFO_DEPTH entries.
  - uart_rdy_o = !full.
  - Simultaneous push on full and pop is allowed only if pop-first ordering is implemented; full is evaluated before the pop, so uart_rdy_o=0 when full.
  - Pointer wrap at FIFO_DEPTH.
- Undefined: single-entry holding register as described above. FIFO_DEPTH is ignored.

Test Plan:
- Basic frame: CLK_HZ=16, BAUD=1, 8N1, send 0xA5.
  - uart_tx sequence is 0,1,0,1,0,0,1,0,1,1, each level held 16 cycles.
  - Start bit begins 1 cycle after accept.
  - uart_done_o pulses once at cycle 160 after the start bit begins.
- Parity and stop bits: 7E2, send 0x41.
  - Parity bit 0; two stop bits totalling 32 cycles.
  - Repeat with odd parity: parity bit 1.
- Back-to-back: offer 0x00 and 0xFF with uart_wr_i held.
  - No idle cycle between the first stop bit end and the second start bit.
  - uart_rdy_o drops while the holding register is full.
- Backpressure (UART_TX_FIFO_EN, FIFO_DEPTH=4): push 6 words continuously.
  - uart_rdy_o deasserts after the 5th accept (1 word in the shifter plus 4 in the FIFO).
  - All 6 words are transmitted in order.
- Reset mid-frame: assert sys_rst_i during DATA bit 3.
  - Next edge: uart_tx=1, uart_busy_o=0, uart_done_o never pulses.
  - A fresh send of 0x3C afterwards is bit-exact.
- Real rate: CLK_HZ=100000000, BAUD=115200, send 0x55.
  - Total frame length is 8680 +/- 1 cycles (10 bits of about 868.06 cycles).
